// File: rtl/srl_fifo_flagged.sv
// Shift-register FIFO with first-word-fall-through read, occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
module srl_fifo_flagged #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    input  logic                  err_clear,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_AF    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_AE    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    logic [ADDR_WIDTH:0]   w_cnt_m1;
    logic [ADDR_WIDTH-1:0] w_raddr;

    // Accepts are gated only by registered flags, so no input-to-flag comb path.
    assign w_wr_ok = if_write & r_full_n;
    assign w_rd_ok = if_read  & r_empty_n;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_ok && !w_rd_ok)
            w_cnt_nxt = r_count + LP_ONE;
        else if (w_rd_ok && !w_wr_ok)
            w_cnt_nxt = r_count - LP_ONE;
    end

    // Oldest entry sits at count-1; a shift plus pop keeps the new oldest there.
    assign w_cnt_m1 = r_count - LP_ONE;
    assign w_raddr  = (r_count == '0) ? '0 : w_cnt_m1[ADDR_WIDTH-1:0];
    assign if_dout  = r_mem[w_raddr];

    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset) begin
            for (int i = DEPTH - 1; i > 0; i--)
                r_mem[i] <= r_mem[i-1];
            r_mem[0] <= if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
            r_af      <= 1'b0;
            r_ae      <= 1'b1;
        end else begin
            r_count   <= w_cnt_nxt;
            r_full_n  <= (w_cnt_nxt <  LP_DEPTH);
            r_empty_n <= (w_cnt_nxt != '0);
            r_af      <= (w_cnt_nxt >= LP_AF);
            r_ae      <= (w_cnt_nxt <= LP_AE);
        end
    end

    // Clear wins over a same-cycle protocol violation.
    always_ff @(posedge clk) begin
        if (reset || err_clear) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (if_write & ~r_full_n);
            r_unf <= r_unf | (if_read  & ~r_empty_n);
        end
    end

    assign if_full_n         = r_full_n;
    assign if_empty_n        = r_empty_n;
    assign if_almost_full    = r_af;
    assign if_almost_empty   = r_ae;
    assign if_num_data_valid = r_count;
    assign overflow          = r_ovf;
    assign underflow         = r_unf;

endmodule

// File: tb/tb_srl_fifo_flagged.sv
// Bench for srl_fifo_flagged: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based FIFO model.
module tb_srl_fifo_flagged;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] if_din = '0;
    logic          if_write = 1'b0;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_read = 1'b0;
    logic          if_empty_n;
    logic          if_almost_full;
    logic          if_almost_empty;
    logic [AW:0]   if_num_data_valid;
    logic          err_clear = 1'b0;
    logic          overflow;
    logic          underflow;

    srl_fifo_flagged #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .reset(reset), .if_din(if_din), .if_write(if_write),
        .if_full_n(if_full_n), .if_dout(if_dout), .if_read(if_read),
        .if_empty_n(if_empty_n), .if_almost_full(if_almost_full),
        .if_almost_empty(if_almost_empty), .if_num_data_valid(if_num_data_valid),
        .err_clear(err_clear), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [DW-1:0] q[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count",   DW'(if_num_data_valid), DW'(n));
        chk("full_n",  DW'(if_full_n),         DW'(n < DEPTH));
        chk("empty_n", DW'(if_empty_n),        DW'(n > 0));
        chk("afull",   DW'(if_almost_full),    DW'(n >= AF));
        chk("aempty",  DW'(if_almost_empty),   DW'(n <= AE));
        chk("ovf",     DW'(overflow),          DW'(m_ovf));
        chk("unf",     DW'(underflow),         DW'(m_unf));
        if (n > 0) chk("dout", if_dout, q[0]);
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare just after it.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit c = 0, input bit rs = 0);
        bit full, empty;
        @(negedge clk);
        if_write  = w;
        if_din    = d;
        if_read   = r;
        err_clear = c;
        reset     = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            m_ovf = c ? 1'b0 : (m_ovf | (w & full));
            m_unf = c ? 1'b0 : (m_unf | (r & empty));
            if (r && !empty) void'(q.pop_front());
            if (w && !full)  q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        // reset then idle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // three writes, three reads
        cyc(1, 32'h11, 0);
        cyc(1, 32'h22, 0);
        cyc(1, 32'h33, 0);
        repeat (3) cyc(0, 0, 1);
        cyc(0, 0, 0);

        // fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0);
        cyc(1, 32'hAA, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);
        cyc(0, 0, 0, 1);

        // simultaneous read+write at full and at count 5
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'(32'h100 + i), 0);
        cyc(1, 32'h99, 1);
        repeat (10) cyc(0, 0, 1);
        cyc(1, 32'h77, 1);
        repeat (5) cyc(0, 0, 1);

        // underflow, then clear together with another empty read
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0);

        // reset in the middle of a write burst
        for (int i = 0; i < 7; i++) cyc(1, DW'(32'h200 + i), 0);
        cyc(1, 32'h300, 0, 0, 1);
        cyc(0, 0, 0);
        cyc(1, 32'h5, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        // random traffic in write-heavy, read-heavy and balanced phases
        for (int ph = 0; ph < 3; ph++) begin
            int wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            int rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            for (int k = 0; k < 1000; k++) begin
                cyc($urandom_range(0, 99) < wp, $urandom,
                    $urandom_range(0, 99) < rp,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 249) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/srl_fifo_flagged.md
Name: srl_fifo_flagged

Overview:
- Parametrised shift-register (SRL) FIFO with a first-word-fall-through read port, an occupancy counter, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Generalises the fixed-depth SRL storage element into a complete FIFO with handshake logic. It is used between HLS dataflow processes, for example start-token and small stream channels feeding PE arrays, where occupancy visibility and protocol-violation detection are needed.

Parameters:
- DATA_WIDTH, 32, width of each entry in bits (>=1).
- DEPTH, 16, number of entries (2..256).
- ADDR_WIDTH, 4, width of the read address and of the count-derived index; must satisfy 2^ADDR_WIDTH >= DEPTH.
- AF_LEVEL, 14, if_almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, if_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_din  in  DATA_WIDTH  write data.
- if_write  in  1  write request.
- if_full_n  out  1  high when count < DEPTH.
- if_dout  out  DATA_WIDTH  oldest entry (FWFT), valid when if_empty_n=1.
- if_read  in  1  read request; pops the entry shown on if_dout.
- if_empty_n  out  1  high when count > 0.
- if_almost_full  out  1  count >= AF_LEVEL.
- if_almost_empty  out  1  count <= AE_LEVEL.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy count.
- err_clear  in  1  clears sticky error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Storage: array of DEPTH entries, no reset on data. An accepted write shifts every entry up one position and loads if_din at index 0.
- Read address = count-1 (0 when count=0). if_dout is combinational from the array at that address; contents are don't-care when empty.
- Accepted write: wr_ok = if_write & if_full_n.
- Accepted read: rd_ok = if_read & if_empty_n.
- Count update, registered, 0..DEPTH:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both: unchanged; shift plus pop leaves the new oldest entry at the same address.
  - neither: hold.
- Flag timing: all flags (if_full_n, if_empty_n, almost flags, if_num_data_valid) are registered and derived from the next count. They are correct in the same cycle the count updates, so latency from an accepted write to if_empty_n=1 is 1 cycle.
- Full boundary (count=DEPTH): if_full_n=0, so a write is ignored; no shift and no data change. A simultaneous read is still accepted and count becomes DEPTH-1.
- Empty boundary (count=0): if_empty_n=0, so a read is ignored. A simultaneous write is accepted; count becomes 1 and the data appears on if_dout the next cycle.
- Errors:
  - overflow set on if_write & ~if_full_n.
  - underflow set on if_read & ~if_empty_n.
  - Both flags hold until err_clear or reset.
  - err_clear has priority over a same-cycle set, so the flag reads 0 the next cycle.
- Reset values: count=0, if_full_n=1, if_empty_n=0, if_almost_full=0 (given AF_LEVEL>=1), if_almost_empty=1, if_num_data_valid=0, overflow=0, underflow=0.
- Reset mid-operation: all contents are logically discarded and accepts in the reset cycle are ignored. Normal operation resumes on the cycle after reset deasserts.
- No combinational path from if_read to if_full_n or from if_write to if_empty_n.

Test Plan:
- Reset, then idle: if_full_n=1, if_empty_n=0, if_almost_empty=1, if_num_data_valid=0, overflow=underflow=0.
- Write 0x11,0x22,0x33 on consecutive cycles, then read three times: if_dout shows 0x11, 0x22, 0x33 in order; if_empty_n rises 1 cycle after the first write and falls after the third read; count runs 1,2,3,2,1,0.
- Fill 16 entries (0..15), with almost_full asserting at count=14. Then write 0xAA while full: if_full_n=0, overflow=1, count stays 16, and reading all 16 returns 0..15 with 0xAA absent.
- At count=16, assert read and write (0x99) together: the write is ignored and count=15. At count=5, assert both with 0x77: count stays 5 and if_dout advances to the next oldest; after draining, 0x77 is the last entry out.
- Read while empty: underflow=1 and count stays 0. Then assert err_clear and if_read together: underflow=0 the next cycle.
- Fill 7 entries, then assert reset for 1 cycle during a write: count=0 and if_empty_n=0 afterwards. The next write of 0x5 is read back as 0x5.
